// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Optional build macro SEG_SCAN_LZB_EN is consumed by seg_scan_ctrl.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2
    } scan_state_e;

    // Largest supported digit count; the index register is sized for it.
    localparam int MAX_DIG = 8;
    localparam int IDX_W   = $clog2(MAX_DIG);

    localparam logic [MAX_DIG-1:0] AN_ALL_OFF = '1;

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot timer: counts 0..DWELL-1 per digit slot and flags the slot end and
// whether the count being loaded this edge still lies inside the blanking gap.
module seg_scan_prescaler
    import seg_scan_pkg::*;
#(
    parameter int DWELL = 1000,
    parameter int BLANK = 16,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    output logic slot_end_o,
    output logic in_gap_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(BLANK);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d      = cnt_q;
        slot_end_o = run_i && (cnt_q == LAST_CNT);
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + ONE;
        end
        // Looks ahead so the FSM can register GAP/SHOW for the next cycle.
        in_gap_o = (cnt_d < GAP_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG common-anode hex digits with a
// double-buffered frame. Define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DWELL = 1000,
    parameter int BLANK = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [4*NDIG-1:0] digits_i,
    input  logic              load_i,
    output logic              load_ack_o,
    output logic [3:0]        val_o,
    output logic [NDIG-1:0]   an_n_o,
    output logic              frame_o
);

    localparam int                FW       = 4 * NDIG;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [NDIG-1:0]   AN_OFF   = AN_ALL_OFF[NDIG-1:0];

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FW-1:0]    disp_q, disp_d;
    logic [FW-1:0]    pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [NDIG-1:0]  an_n_q, an_n_d;
    logic [3:0]       val_q, val_d;
    logic             ack_q, ack_d;
    logic             frame_q, frame_d;
    logic             commit;
    logic             lit;
    logic             slot_end;
    logic             in_gap;

`ifdef SEG_SCAN_LZB_EN
    logic [IDX_W-1:0] hi_q, hi_d;

    function automatic logic [IDX_W-1:0] hi_nz(input logic [FW-1:0] f);
        logic [IDX_W-1:0] h;
        h = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (f[4*k +: 4] != 4'h0) h = IDX_W'(k);
        end
        return h;
    endfunction
`endif

    seg_scan_prescaler #(
        .DWELL (DWELL),
        .BLANK (BLANK),
        .CNT_W (CNT_W)
    ) u_presc (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (state_q != ST_IDLE),
        .clr_i      (state_q == ST_IDLE),
        .slot_end_o (slot_end),
        .in_gap_o   (in_gap)
    );

    // Slot sequencing; frame_d marks the first cycle of a digit-0 slot.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (en_i) begin
                    state_d = in_gap ? ST_GAP : ST_SHOW;
                    frame_d = 1'b1;
                end
            end
            ST_GAP, ST_SHOW: begin
                if (slot_end && !en_i) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    state_d = in_gap ? ST_GAP : ST_SHOW;
                    if (slot_end) begin
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
                        frame_d = (idx_q == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Display buffer only changes at a frame boundary; a load landing on the
    // boundary bypasses the pending buffer.
    always_comb begin
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ack_d    = 1'b0;
        commit   = frame_d && (pend_v_q || load_i);
        if (load_i) begin
            pend_d   = digits_i;
            pend_v_d = 1'b1;
        end
        if (commit) begin
            disp_d   = load_i ? digits_i : pend_q;
            pend_v_d = 1'b0;
            ack_d    = 1'b1;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        hi_d = commit ? hi_nz(disp_d) : hi_q;
        lit  = (state_d == ST_SHOW) && (idx_d <= hi_d);
    end
`else
    always_comb begin
        lit = (state_d == ST_SHOW);
    end
`endif

    // Outputs are decoded from next state and registered, so pins never glitch.
    always_comb begin
        an_n_d = AN_OFF;
        val_d  = 4'h0;
        if (state_d != ST_IDLE) begin
            for (int k = 0; k < NDIG; k++) begin
                if (idx_d == IDX_W'(k)) val_d = disp_d[4*k +: 4];
            end
        end
        if (lit) begin
            for (int k = 0; k < NDIG; k++) begin
                if (idx_d == IDX_W'(k)) an_n_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            an_n_q   <= AN_OFF;
            val_q    <= 4'h0;
            ack_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            an_n_q   <= an_n_d;
            val_q    <= val_d;
            ack_q    <= ack_d;
            frame_q  <= frame_d;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end
`endif

    assign an_n_o     = an_n_q;
    assign val_o      = val_q;
    assign load_ack_o = ack_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed steps plus random traffic against a
// frame-time reference model (honours SEG_SCAN_LZB_EN when defined).
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int CNT_W = 4;
    localparam int SLOTS = DWELL * NDIG;
`ifdef SEG_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] din;
    logic        load;
    logic        ack;
    logic [3:0]  val;
    logic [3:0]  an_n;
    logic        frame;

    seg_scan_ctrl #(
        .NDIG  (NDIG),
        .DWELL (DWELL),
        .BLANK (BLANK),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .digits_i   (din),
        .load_i     (load),
        .load_ack_o (ack),
        .val_o      (val),
        .an_n_o     (an_n),
        .frame_o    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within the frame is a single cycle count.
    bit          m_run;
    int          m_age;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;
    logic [3:0]  e_an;
    logic [3:0]  e_val;
    logic        e_frame;
    logic        e_ack;

    function automatic int hnz(input logic [15:0] f);
        int h = 0;
        for (int k = 0; k < NDIG; k++)
            if (f[4*k +: 4] != 4'h0) h = k;
        return h;
    endfunction

    task automatic model_reset();
        m_run = 0; m_age = 0; m_disp = '0; m_pend = '0; m_pv = 0;
        e_an = 4'hF; e_val = 4'h0; e_frame = 1'b0; e_ack = 1'b0;
    endtask

    task automatic model_step();
        bit bnd;
        int idx;
        int c;
        bit on;
        logic [3:0] one;
        bnd = 0;
        one = 4'b0001;
        if (!m_run) begin
            if (en) begin m_run = 1; m_age = 0; bnd = 1; end
        end else if ((m_age % DWELL) == DWELL - 1 && !en) begin
            m_run = 0;
        end else begin
            m_age = (m_age + 1) % SLOTS;
            bnd = (m_age == 0);
        end
        e_ack = 1'b0;
        if (bnd && (load || m_pv)) begin
            m_disp = load ? din : m_pend;
            m_pv = 0;
            e_ack = 1'b1;
        end else if (load) begin
            m_pend = din;
            m_pv = 1;
        end
        e_frame = bnd;
        if (!m_run) begin
            e_an = 4'hF; e_val = 4'h0;
        end else begin
            idx = m_age / DWELL;
            c = m_age % DWELL;
            e_val = m_disp[4*idx +: 4];
            on = (c >= BLANK) && (!LZB || idx <= hnz(m_disp));
            e_an = on ? ~(one << idx) : 4'hF;
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (an_n === e_an) else begin
            miscompares++;
            $error("FAIL %s an_n_o observed=%b expected=%b", tag, an_n, e_an);
        end
        vectors++;
        assert (val === e_val) else begin
            miscompares++;
            $error("FAIL %s val_o observed=%h expected=%h", tag, val, e_val);
        end
        vectors++;
        assert (frame === e_frame) else begin
            miscompares++;
            $error("FAIL %s frame_o observed=%b expected=%b", tag, frame, e_frame);
        end
        vectors++;
        assert (ack === e_ack) else begin
            miscompares++;
            $error("FAIL %s load_ack_o observed=%b expected=%b", tag, ack, e_ack);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic advance_to(input int a, input string tag);
        for (int i = 0; i < SLOTS + 2; i++) begin
            if (m_run && m_age == a) break;
            tick(tag);
        end
    endtask

    task automatic load_word(input logic [15:0] w, input string tag);
        din = w; load = 1'b1;
        tick(tag);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset");
        rst_n = 1'b1;
        ticks(20, "idle");

        load_word(16'h4321, "load_4321");
        en = 1'b1;
        ticks(3 * SLOTS, "scan_order");

        advance_to(5, "seek_mid");
        load_word(16'hAAAA, "load_aaaa");
        ticks(6, "dbuf_hold");
        load_word(16'h5555, "load_5555");
        ticks(2 * SLOTS, "dbuf");

        load_word(16'h1111, "load_1111");
        advance_to(SLOTS - 1, "seek_bnd");
        load_word(16'h9876, "collide");
        ticks(SLOTS + 3, "post_collide");

        load_word(16'h0042, "load_0042");
        ticks(2 * SLOTS, "lzb_0042");
        load_word(16'h0000, "load_0000");
        ticks(2 * SLOTS, "lzb_0000");

        advance_to(SLOTS / 2 + 3, "seek_dis");
        en = 1'b0;
        load_word(16'h00F0, "load_idle");
        ticks(DWELL + 6, "disable");
        en = 1'b1;
        ticks(SLOTS + 2, "reenable");

        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 24) != 0);
            load = ($urandom_range(0, 6) == 0);
            din = 16'($urandom);
            if ($urandom_range(0, 2) == 0) din = din & 16'h00FF;
            if ($urandom_range(0, 4) == 0) din = din & 16'h000F;
            tick("random");
        end
        load = 1'b0;
        en = 1'b1;

        load_word(16'h3A5C, "load_pre_rst");
        advance_to(DWELL + 4, "seek_show");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(negedge clk);
        check("rst_hold");
        rst_n = 1'b1;
        ticks(SLOTS + 4, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
